// File: rtl/input_port_fifo.sv
// Router input port: BUFFER_DEPTH-entry flit FIFO with XY routing at ingress and one-hot request/grant egress.
// Optional INPUT_PORT_STATS_EN adds flit_cnt/drop_cnt statistics ports.
module input_port_fifo #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned BUFFER_DEPTH    = 4,
  parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
  parameter logic [4:0]  DIRECTION       = 5'b00001,
  parameter int unsigned DEST_LSB        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  si,
  output logic                  ro,
  input  logic [DATA_WIDTH-1:0] datai,
  output logic [4:0]            reqo,
  output logic [DATA_WIDTH-1:0] datao,
  input  logic [4:0]            gnt,
  output logic                  err
`ifdef INPUT_PORT_STATS_EN
  ,
  output logic [15:0]           flit_cnt,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int unsigned PW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [4:0] {
    DIR_L  = 5'b10000,
    DIR_R  = 5'b01000,
    DIR_U  = 5'b00100,
    DIR_D  = 5'b00010,
    DIR_PE = 5'b00001
  } dir_e;

  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] flit_mem  [BUFFER_DEPTH];
  logic [4:0]            route_mem [BUFFER_DEPTH];

  logic [7:0] dx, dy;
  dir_e       route;
  logic       uturn, push, pop, drop, not_empty;

  always_comb begin
    dx = datai[DEST_LSB+15 -: 8];
    dy = datai[DEST_LSB+7 -: 8];
    route = DIR_PE;
    if (dx > CURRENT_ADDRESS[15:8])      route = DIR_R;
    else if (dx < CURRENT_ADDRESS[15:8]) route = DIR_L;
    else if (dy > CURRENT_ADDRESS[7:0])  route = DIR_U;
    else if (dy < CURRENT_ADDRESS[7:0])  route = DIR_D;
  end

  // A flit heading back out of the side it arrived on is dropped; PE traffic never U-turns.
  assign uturn     = (route == DIRECTION) && (DIRECTION != DIR_PE);
  assign not_empty = (count != '0);
  assign ro        = (count != CW'(BUFFER_DEPTH));
  assign reqo      = not_empty ? route_mem[rptr] : '0;
  assign datao     = not_empty ? flit_mem[rptr] : '0;
  assign push      = si && ro && !uturn;
  assign drop      = si && ro && uturn;
  assign pop       = |(gnt & reqo);

  always_ff @(posedge clk) begin
    if (push) begin
      flit_mem[wptr]  <= datai;
      route_mem[wptr] <= route;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      err <= drop;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef INPUT_PORT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) flit_cnt <= flit_cnt + 16'd1;
      if (drop) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_input_port_fifo.sv
// Randomized self-checking bench for input_port_fifo against a queue-based reference model.
module tb_input_port_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LSB   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          si = 1'b0, ro, err;
  logic [DW-1:0] datai = '0, datao;
  logic [4:0]    reqo, gnt = '0;

  logic          si_l = 1'b0, ro_l, err_l;
  logic [DW-1:0] datai_l = '0, datao_l;
  logic [4:0]    reqo_l, gnt_l = '0;

`ifdef INPUT_PORT_STATS_EN
  logic [15:0] flit_cnt, flit_cnt_l;
  logic [7:0]  drop_cnt, drop_cnt_l;
`endif

  input_port_fifo #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .CURRENT_ADDRESS(16'h0202),
    .DIRECTION(5'b00001), .DEST_LSB(LSB)
  ) dut (
    .clk(clk), .rst(rst), .si(si), .ro(ro), .datai(datai),
    .reqo(reqo), .datao(datao), .gnt(gnt), .err(err)
`ifdef INPUT_PORT_STATS_EN
    , .flit_cnt(flit_cnt), .drop_cnt(drop_cnt)
`endif
  );

  input_port_fifo #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .CURRENT_ADDRESS(16'h0202),
    .DIRECTION(5'b10000), .DEST_LSB(LSB)
  ) dut_l (
    .clk(clk), .rst(rst), .si(si_l), .ro(ro_l), .datai(datai_l),
    .reqo(reqo_l), .datao(datao_l), .gnt(gnt_l), .err(err_l)
`ifdef INPUT_PORT_STATS_EN
    , .flit_cnt(flit_cnt_l), .drop_cnt(drop_cnt_l)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ordered list of (route, flit) for the PE-side port at 0202.
  typedef struct {
    logic [4:0]    r;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];
  logic err_exp = 1'b0;
  int   n_push  = 0;

  function automatic logic [4:0] route_of(input logic [DW-1:0] f);
    int x, y;
    x = int'(f[LSB+15 -: 8]);
    y = int'(f[LSB+7 -: 8]);
    if (x > 2) return 5'b01000;
    if (x < 2) return 5'b10000;
    if (y > 2) return 5'b00100;
    if (y < 2) return 5'b00010;
    return 5'b00001;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [15:0] dest);
    logic [DW-1:0] f;
    f = $urandom;
    f[LSB+15 -: 16] = dest;
    return f;
  endfunction

  function automatic logic [4:0] head_route();
    return (q.size() != 0) ? q[0].r : 5'b00000;
  endfunction

  // Called just after a falling edge: check registered outputs, apply inputs, advance model over the next rising edge.
  task automatic cycle(input logic s, input logic [DW-1:0] d, input logic [4:0] g);
    logic          ro_e, psh, pp;
    logic [4:0]    rq_e, r;
    logic [DW-1:0] do_e;
    si = s; datai = d; gnt = g;
    ro_e = (q.size() < DEPTH);
    rq_e = head_route();
    do_e = (q.size() != 0) ? q[0].d : '0;
    #1;
    check("ro", ro, ro_e);
    check("reqo", reqo, rq_e);
    check("datao", datao, do_e);
    check("err", err, err_exp);
    r   = route_of(d);
    psh = s && ro_e;
    pp  = (g & rq_e) != 0;
    err_exp = 1'b0;
    if (pp) void'(q.pop_front());
    if (psh) begin
      q.push_back('{r: r, d: d});
      n_push++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0]   t2_dest [5] = '{16'h0302, 16'h0102, 16'h0203, 16'h0201, 16'h0202};
  logic [4:0]    t2_rt   [5] = '{5'b01000, 5'b10000, 5'b00100, 5'b00010, 5'b00001};
  logic [DW-1:0] fl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with si asserted
    si = 1'b1; datai = mk(16'h0302);
    repeat (3) @(negedge clk);
    check("rst_ro", ro, 1'b1);
    check("rst_reqo", reqo, 5'b0);
    check("rst_err", err, 1'b0);
    check("rst_datao", datao, '0);
    si = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    cycle(1'b0, '0, 5'b0);

    // 2: one flit per direction, popped by matching grant
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, mk(t2_dest[i]), 5'b0);
      check("t2_route", reqo, t2_rt[i]);
      cycle(1'b0, '0, t2_rt[i]);
      check("t2_empty", reqo, 5'b0);
    end

    // 3: overfill with no grants
    for (int i = 0; i < 6; i++) begin
      fl[i] = mk(16'h0302);
      cycle(1'b1, fl[i], 5'b0);
    end
    check("t3_full_ro", ro, 1'b0);
    check("t3_head", datao, fl[0]);
    cycle(1'b0, '0, 5'b01000);
    check("t3_ro_back", ro, 1'b1);
    check("t3_head2", datao, fl[1]);
    while (q.size() != 0) cycle(1'b0, '0, head_route());

    // 4: stream through a half-full FIFO across pointer wrap
    cycle(1'b1, mk(16'h0203), 5'b0);
    cycle(1'b1, mk(16'h0201), 5'b0);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, mk(16'($urandom_range(0, 4) << 8 | $urandom_range(0, 4))), head_route());
    check("t4_count", 32'(q.size()), 32'd2);
    while (q.size() != 0) cycle(1'b0, '0, head_route());

    // 5: U-turn drop on the L-side port
    si_l = 1'b1; datai_l = mk(16'h0102);
    @(negedge clk);
    si_l = 1'b0;
    check("t5_err", err_l, 1'b1);
    check("t5_reqo", reqo_l, 5'b0);
`ifdef INPUT_PORT_STATS_EN
    check("t5_drop_cnt", drop_cnt_l, 8'd1);
    check("t5_flit_cnt", flit_cnt_l, 16'd0);
`endif
    @(negedge clk);
    check("t5_err_pulse", err_l, 1'b0);
    si_l = 1'b1; datai_l = mk(16'h0302);
    @(negedge clk);
    si_l = 1'b0;
    check("t5_ok_reqo", reqo_l, 5'b01000);
    check("t5_ok_err", err_l, 1'b0);
    gnt_l = 5'b01000;
    @(negedge clk);
    gnt_l = 5'b0;
    check("t5_popped", reqo_l, 5'b0);

    // 6: mismatched grant, then asynchronous reset mid-stream
    cycle(1'b1, mk(16'h0302), 5'b0);
    cycle(1'b1, mk(16'h0102), 5'b00100);
    cycle(1'b0, '0, 5'b10110);
    check("t6_hold", reqo, 5'b01000);
    #2 rst = 1'b0;
    #1;
    check("t6_arst_reqo", reqo, 5'b0);
    check("t6_arst_ro", ro, 1'b1);
    check("t6_arst_datao", datao, '0);
    q.delete();
    err_exp = 1'b0;
    n_push = 0;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0, 5'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] g;
      case ($urandom_range(0, 3))
        0: g = 5'b0;
        1: g = head_route();
        2: g = 5'($urandom);
        default: g = 5'b11111;
      endcase
      cycle($urandom_range(0, 2) != 0,
            mk(16'($urandom_range(0, 4) << 8 | $urandom_range(0, 4))), g);
    end
`ifdef INPUT_PORT_STATS_EN
    check("flit_cnt", flit_cnt, 16'(n_push));
    check("drop_cnt", drop_cnt, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
